// File: rtl/tos_alu_mc.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// tos_alu_mc : iterative MUL / DIVMOD / multi-bit shift unit beside the TOS path
// Revision   : 1.0
// =============================================================================
module tos_alu_mc #(
   parameter int WIDTH      = 16,
   parameter int SHIFT_STEP = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] TOS,
   input  logic [WIDTH-1:0] arg,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             div0
);
   localparam int               CW       = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]    CNT_FULL = CW'(WIDTH);
   localparam logic [CW-1:0]    CNT_STEP = CW'(SHIFT_STEP);
   localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
   localparam logic [WIDTH-1:0] TOS_FULL = WIDTH'(WIDTH);
   localparam logic [2:0]       OP_MUL   = 3'd0;
   localparam logic [2:0]       OP_DIV   = 3'd1;
   localparam logic [2:0]       OP_LSH   = 3'd2;
   localparam logic [2:0]       OP_RSH   = 3'd3;
   localparam logic [2:0]       OP_ASH   = 3'd4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] result_hi_q, result_hi_d;
   logic             div0_q, div0_d;

   logic [CW-1:0]    n_shift;
   logic [CW-1:0]    step;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_sh;
   logic [WIDTH:0]   div_diff;

   // lo/hi hold the running product, quotient/remainder or shifted value
   always_comb begin
      n_shift  = (TOS >= TOS_FULL) ? CNT_FULL : TOS[CW-1:0];
      step     = (cnt_q < CNT_STEP) ? cnt_q : CNT_STEP;
      mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      div_sh   = {hi_q, lo_q[WIDTH-1]};
      div_diff = div_sh - {1'b0, b_q};
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      lo_d        = lo_q;
      hi_d        = hi_q;
      b_d         = b_q;
      cnt_d       = cnt_q;
      result_d    = result_q;
      result_hi_d = result_hi_q;
      div0_d      = div0_q;
      case (state_q)
         S_RUN: begin
            case (op_q)
               OP_MUL: {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
               OP_DIV: begin
                  hi_d = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
                  lo_d = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
               end
               OP_LSH:  lo_d = lo_q << step;
               OP_RSH:  lo_d = lo_q >> step;
               default: lo_d = $signed(lo_q) >>> step;
            endcase
            cnt_d = (op_q == OP_MUL || op_q == OP_DIV) ? cnt_q - CNT_ONE : cnt_q - step;
            if (cnt_d == '0) begin
               state_d     = S_DONE;
               result_d    = lo_d;
               result_hi_d = hi_d;
            end
         end
         default: begin
            state_d = S_IDLE;
            if (start) begin
               op_d    = op;
               div0_d  = 1'b0;
               hi_d    = '0;
               lo_d    = arg;
               b_d     = TOS;
               state_d = S_RUN;
               case (op)
                  OP_MUL: begin
                     lo_d  = TOS;
                     b_d   = arg;
                     cnt_d = CNT_FULL;
                  end
                  OP_DIV: begin
                     cnt_d = CNT_FULL;
                     if (TOS == '0) begin
                        state_d     = S_DONE;
                        div0_d      = 1'b1;
                        result_d    = '1;
                        result_hi_d = arg;
                     end
                  end
                  OP_LSH, OP_RSH, OP_ASH: begin
                     cnt_d = n_shift;
                     if (n_shift == '0) begin
                        state_d     = S_DONE;
                        result_d    = arg;
                        result_hi_d = '0;
                     end
                  end
                  default: begin
                     state_d     = S_DONE;
                     result_d    = '0;
                     result_hi_d = '0;
                  end
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         lo_q        <= '0;
         hi_q        <= '0;
         b_q         <= '0;
         cnt_q       <= '0;
         result_q    <= '0;
         result_hi_q <= '0;
         div0_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         lo_q        <= lo_d;
         hi_q        <= hi_d;
         b_q         <= b_d;
         cnt_q       <= cnt_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         div0_q      <= div0_d;
      end
   end

   assign busy      = (state_q == S_RUN);
   assign done      = (state_q == S_DONE);
   assign result    = result_q;
   assign result_hi = result_hi_q;
   assign div0      = div0_q;

endmodule
`default_nettype wire

// File: tb/tb_tos_alu_mc.sv
`default_nettype none
`timescale 1ns/1ps
// tb_tos_alu_mc : randomized scoreboard bench for tos_alu_mc (16-bit main
// instance plus a 32-bit, 4-bit-step instance for wide-step shifts).
module tb_tos_alu_mc;
   localparam int W = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [2:0]    op = '0;
   logic [W-1:0]  tos = '0;
   logic [W-1:0]  arg = '0;
   logic          busy, done, div0;
   logic [W-1:0]  result, result_hi;

   logic          start2 = 1'b0;
   logic [2:0]    op2 = '0;
   logic [31:0]   tos2 = '0;
   logic [31:0]   arg2 = '0;
   logic          busy2, done2, div02;
   logic [31:0]   result2, result_hi2;

   tos_alu_mc #(.WIDTH(W), .SHIFT_STEP(1)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .TOS(tos), .arg(arg),
      .busy(busy), .done(done), .result(result), .result_hi(result_hi), .div0(div0)
   );

   tos_alu_mc #(.WIDTH(32), .SHIFT_STEP(4)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .op(op2), .TOS(tos2), .arg(arg2),
      .busy(busy2), .done(done2), .result(result2), .result_hi(result_hi2), .div0(div02)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [15:0] r;
      logic [15:0] h;
      logic        d0;
      int          lat;
      int          t0;
   } exp_t;

   exp_t        sb[$];
   int          ncmp = 0;
   int          nfail = 0;
   int          busy_cnt = 0;
   logic [15:0] last_r = '0;
   logic [15:0] last_h = '0;
   bit          in_rst = 1'b1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model straight from the arithmetic definition of each op
   function automatic exp_t model(input logic [2:0] o, input logic [15:0] t, input logic [15:0] a);
      exp_t        e;
      logic [31:0] p;
      int          n;
      e = '0;
      case (o)
         3'd0: begin
            p     = 32'(a) * 32'(t);
            e.r   = p[15:0];
            e.h   = p[31:16];
            e.lat = W + 1;
         end
         3'd1: begin
            if (t == 16'd0) begin
               e.r = 16'hFFFF; e.h = a; e.d0 = 1'b1; e.lat = 1;
            end else begin
               e.r = a / t; e.h = a % t; e.lat = W + 1;
            end
         end
         3'd2, 3'd3, 3'd4: begin
            n     = (t >= 16'd16) ? 16 : int'(t);
            e.lat = n + 1;
            if (o == 3'd2)      p = {16'h0000, a} << n;
            else if (o == 3'd3) p = {16'h0000, a} >> n;
            else                p = {{16{a[15]}}, a} >> n;
            e.r = p[15:0];
            e.h = 16'h0000;
         end
         default: e.lat = 1;
      endcase
      return e;
   endfunction

   // Monitor: every done pulse retires the oldest outstanding op
   always @(negedge clk) begin
      exp_t e;
      if (!in_rst) begin
         if (done) begin
            if (sb.size() == 0) begin
               ncmp++;
               nfail++;
               $display("FAIL unexpected_done: got done=1 expected no outstanding op (cycle %0d)", cyc);
            end else begin
               e = sb.pop_front();
               chk("result",       32'(result),        32'(e.r));
               chk("result_hi",    32'(result_hi),     32'(e.h));
               chk("div0",         32'(div0),          32'(e.d0));
               chk("latency",      32'(cyc - e.t0),    32'(e.lat));
               chk("busy_cycles",  32'(busy_cnt),      32'(e.lat - 1));
               chk("busy_at_done", 32'(busy),          32'd0);
            end
            busy_cnt = 0;
            last_r   = result;
            last_h   = result_hi;
         end else if (busy) begin
            busy_cnt++;
            chk("held_result", {result_hi, result}, {last_h, last_r});
         end
      end
   end

   // Called at a negedge; returns at the following negedge with start low
   task automatic issue(input logic [2:0] o, input logic [15:0] t, input logic [15:0] a);
      exp_t e;
      int   guard;
      guard = 0;
      while (busy) begin
         start = 1'($urandom_range(0, 1));
         op    = 3'($urandom);
         tos   = 16'($urandom);
         arg   = 16'($urandom);
         @(negedge clk);
         guard++;
         if (guard > 100) begin
            $display("FAIL busy_timeout: got busy stuck expected release within 100 cycles");
            $fatal(1, "busy never released");
         end
      end
      start = 1'b1;
      op    = o;
      tos   = t;
      arg   = a;
      e     = model(o, t, a);
      e.t0  = cyc;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      op    = 3'($urandom);
      tos   = 16'($urandom);
      arg   = 16'($urandom);
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((sb.size() != 0 || busy) && g < 200) begin
         @(negedge clk);
         g++;
      end
      chk("drain_timeout", 32'(g >= 200), 32'd0);
   endtask

   task automatic run2(input logic [2:0] o, input logic [31:0] t, input logic [31:0] a,
                       input logic [31:0] er, input logic [31:0] eh, input int elat, input string nm);
      int n;
      @(negedge clk);
      start2 = 1'b1;
      op2    = o;
      tos2   = t;
      arg2   = a;
      @(negedge clk);
      start2 = 1'b0;
      arg2   = 32'($urandom);
      tos2   = 32'($urandom);
      n      = 1;
      while (!done2 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_result"},    result2,    er);
      chk({nm, "_result_hi"}, result_hi2, eh);
      chk({nm, "_latency"},   32'(n),     32'(elat));
   endtask

   function automatic logic [15:0] rand_tos();
      case ($urandom_range(0, 4))
         0:       return 16'd0;
         1:       return 16'($urandom_range(0, 17));
         2:       return 16'd16;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      int ndone;
      int nbusy;
      #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_done",      32'(done),      32'd0);
      chk("rst_result",    32'(result),    32'd0);
      chk("rst_result_hi", 32'(result_hi), 32'd0);
      chk("rst_div0",      32'(div0),      32'd0);
      #2 reset = 1'b1;
      in_rst = 1'b0;
      @(negedge clk);

      issue(3'd0, 16'h0100, 16'h1234);
      issue(3'd1, 16'd7,    16'd1000);
      issue(3'd1, 16'd0,    16'h00AB);
      issue(3'd4, 16'd3,    16'h8000);
      issue(3'd3, 16'd20,   16'hFFFF);
      issue(3'd2, 16'd0,    16'h00F0);
      issue(3'd5, 16'h1234, 16'h5678);
      issue(3'd2, 16'd16,   16'hFFFF);
      issue(3'd4, 16'hFFFF, 16'h8001);

      repeat (400) begin
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
         issue(3'($urandom_range(0, 7)), rand_tos(), 16'($urandom));
      end
      drain();

      issue(3'd0, 16'd5, 16'd3);
      drain();
      issue(3'd0, 16'h0100, 16'h1234);
      repeat (7) @(negedge clk);
      #2;
      in_rst = 1'b1;
      reset  = 1'b0;
      #1;
      chk("abort_busy",      32'(busy),      32'd0);
      chk("abort_done",      32'(done),      32'd0);
      chk("abort_result",    32'(result),    32'd0);
      chk("abort_result_hi", 32'(result_hi), 32'd0);
      sb.delete();
      repeat (2) @(negedge clk);
      #2;
      reset    = 1'b1;
      last_r   = '0;
      last_h   = '0;
      busy_cnt = 0;
      in_rst   = 1'b0;
      ndone    = 0;
      nbusy    = 0;
      repeat (25) begin
         @(negedge clk);
         if (done) ndone++;
         if (busy) nbusy++;
      end
      chk("no_done_after_reset", 32'(ndone), 32'd0);
      chk("idle_after_reset",    32'(nbusy), 32'd0);

      run2(3'd2, 32'd9,          32'h0000_0001, 32'h0000_0200, 32'd0,         4,  "w32_lsh9");
      run2(3'd3, 32'd7,          32'hF000_0000, 32'h01E0_0000, 32'd0,         3,  "w32_rsh7");
      run2(3'd4, 32'd40,         32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         9,  "w32_ash40");
      run2(3'd0, 32'h0003_0000,  32'h0001_0000, 32'h0000_0000, 32'h0000_0003, 33, "w32_mul");
      run2(3'd1, 32'd0,          32'd100,       32'hFFFF_FFFF, 32'd100,       1,  "w32_div0");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got simulation still running expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
